spi_txc: RTL and testbench
==========================

// Module: spi_txc
// PURPOSE
//   SPI transmit controller: serialises 8/16/32-bit frames from spi_tx_data onto shift_out, one bit per sclk_tx.
//   Runs bursts of spi_tnum+1 frames and optionally appends a CRC frame.
//   Sits between the TX data buffer and the SPI pad logic; the CRC value is also exported.
// PARAMETERS
//   none (frame widths fixed at 8/16/32; shared constants live in spi_txc_pkg)
// PORTS
//   sclk_tx        in   1   transmit shift clock (single clock domain)
//   spi_tx_rstn    in   1   reset, asynchronous, active-low
//   spi_tx_data    in   32  frame data; low 8/16/32 bits used per df
//   df             in   2   frame format: 00=8b, 01=16b, 10=32b, 11=8b (reserved)
//   spi_tnum       in   13  frames per burst minus 1
//   lsbf           in   1   1=LSB first, 0=MSB first (data and CRC frames)
//   crc_en         in   1   append CRC frame after last data frame
//   txe            in   1   transmit enable
//   rxonly         in   1   receive-only: transmitter inhibited
//   crc_poly       in   32  CRC polynomial, implicit top bit; masked to frame width
//   crc_data_out   out  32  running CRC register, zero-extended
//   tx_start       out  1   one-cycle pulse at burst start
//   tx_num_max_en  out  1   high throughout the last data frame (frame_cnt==spi_tnum)
//   shift_out      out  1   serial data out
// BEHAVIOUR
//   Reset (async, spi_tx_rstn=0): state IDLE, all outputs 0, counters and CRC 0.
//   States: IDLE -> DATA -> (CRC) -> IDLE.
//   IDLE: if txe & !rxonly, next edge enters DATA; capture df, spi_tnum, lsbf, crc_en, crc_poly
//     (held for the whole burst); load shift reg with spi_tx_data; bit_cnt=W-1; frame_cnt=0;
//     CRC reg=0; tx_start=1 for exactly that first DATA cycle.
//   DATA: shift_out = sreg[W-1] (MSB-first) or sreg[0] (LSB-first), combinational from the register.
//     Each edge shifts one bit and decrements bit_cnt.
//     At bit_cnt==0: if frame_cnt<tnum, frame_cnt++ and reload from current spi_tx_data (no gap cycle).
//     Otherwise go to CRC if crc_en, else IDLE.
//   CRC: load shift reg with CRC reg snapshot (W bits), shift W bits per lsbf, then IDLE.
//     CRC reg frozen while in CRC state.
//   CRC update per transmitted data bit b: fb=crc[W-1]^b; crc={crc[W-2:0],1'b0}^(fb?poly[W-1:0]:0).
//   W = 8/16/32 per df; crc_data_out = CRC reg; value persists until the next tx_start.
//   IDLE: shift_out=0, tx_num_max_en=0. At least one IDLE cycle between bursts;
//     txe still high after a burst starts a new burst.
//   txe falling or rxonly rising mid-burst: abort at next edge to IDLE, shift_out=0, CRC reg kept.
//   Input changes to df/spi_tnum/lsbf/crc_en/crc_poly mid-burst are ignored.
//   rxonly=1: never leaves IDLE; tx_start never pulses.
// CONFIGURATION
//   SPI_TXC_CRC_EN defined: CRC generator and CRC state present as above.
//   SPI_TXC_CRC_EN undefined: crc_en ignored (no CRC frame), crc_data_out tied 0, CRC logic removed.
// STRUCTURE
//   spi_txc_pkg: df encodings, frame-width constants (8/16/32), state enum (IDLE/DATA/CRC).
//   Sub-module spi_txc_crc: serial CRC LFSR (clear, enable, bit, width, poly -> crc), instantiated under SPI_TXC_CRC_EN.
// TESTING
//   df=00, tnum=4, lsbf=0, data=0x12345678, txe=1
//     -> one tx_start pulse; shift_out 0,1,1,1,1,0,0,0 x5 (40 cycles);
//        tx_num_max_en high for bits 33-40; then IDLE.
//   df=01, tnum=2, lsbf=1, data=0xAABBCCDD
//     -> each frame 1,0,1,1,1,0,1,1,0,0,1,1,0,0,1,1; 48 data cycles.
//   df=00, tnum=0, crc_en=1, crc_poly=0x07, data=0x01
//     -> crc_data_out=0x00000007 after data frame; CRC frame 0,0,0,0,0,1,1,1 follows.
//   df=10, tnum=1, crc_en=1, crc_poly=0x04C11DB7, data=0x87654321
//     -> 64 data bits then 32 CRC bits; crc_data_out matches bit-serial model.
//   rxonly=1, txe=1, data=0xFFFFFFFF -> shift_out stays 0, tx_start never asserts.
//   Reset asserted mid-frame -> all outputs 0 immediately; new burst starts cleanly after release.

Source files
------------

// File: rtl/spi_txc_pkg.sv
// rtl/spi_txc_pkg.sv - shared frame formats, widths and state encoding for spi_txc
package spi_txc_pkg;

    localparam logic [1:0] DF_8  = 2'b00;
    localparam logic [1:0] DF_16 = 2'b01;
    localparam logic [1:0] DF_32 = 2'b10;

    localparam int FW_8  = 8;
    localparam int FW_16 = 16;
    localparam int FW_32 = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_CRC  = 2'b10
    } state_t;

    // Reserved df=11 falls back to 8-bit frames.
    function automatic logic [4:0] frame_msb(input logic [1:0] df);
        case (df)
            DF_16:   frame_msb = 5'(FW_16 - 1);
            DF_32:   frame_msb = 5'(FW_32 - 1);
            DF_8:    frame_msb = 5'(FW_8 - 1);
            default: frame_msb = 5'(FW_8 - 1);
        endcase
    endfunction

    function automatic logic [31:0] frame_mask(input logic [1:0] df);
        case (df)
            DF_16:   frame_mask = 32'h0000_FFFF;
            DF_32:   frame_mask = 32'hFFFF_FFFF;
            default: frame_mask = 32'h0000_00FF;
        endcase
    endfunction

endpackage

// File: rtl/spi_txc_crc.sv
// rtl/spi_txc_crc.sv - bit-serial CRC LFSR, width follows the frame format
module spi_txc_crc
    import spi_txc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    input  logic [1:0]  df,
    input  logic [31:0] poly,
    output logic [31:0] crc,
    output logic [31:0] crc_nxt
);

    logic        fb;
    logic [31:0] mask;

    assign mask    = frame_mask(df);
    assign fb      = crc[frame_msb(df)] ^ bit_in;
    // Exposed so the CRC frame can be loaded on the same edge as the final data bit.
    assign crc_nxt = ((crc << 1) ^ (fb ? poly : 32'd0)) & mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc_nxt;
        end
    end

endmodule

// File: rtl/spi_txc.sv
// rtl/spi_txc.sv - SPI transmit controller; CRC frame generation present only with SPI_TXC_CRC_EN
module spi_txc
    import spi_txc_pkg::*;
(
    input  logic        sclk_tx,
    input  logic        spi_tx_rstn,
    input  logic [31:0] spi_tx_data,
    input  logic [1:0]  df,
    input  logic [12:0] spi_tnum,
    input  logic        lsbf,
    input  logic        crc_en,
    input  logic        txe,
    input  logic        rxonly,
    input  logic [31:0] crc_poly,
    output logic [31:0] crc_data_out,
    output logic        tx_start,
    output logic        tx_num_max_en,
    output logic        shift_out
);

    state_t      state, state_nxt;
    logic [1:0]  df_q;
    logic [12:0] tnum_q;
    logic        lsbf_q;
    logic [31:0] sreg;
    logic [4:0]  bit_cnt;
    logic [12:0] frame_cnt;
    logic        run, start, last_bit, last_frame, crc_go;
    logic [4:0]  msb;
    logic [31:0] sreg_shift, crc_nxt;

    assign run        = txe & ~rxonly;
    assign msb        = frame_msb(df_q);
    assign last_bit   = (bit_cnt == 5'd0);
    assign last_frame = (frame_cnt == tnum_q);
    assign sreg_shift = lsbf_q ? (sreg >> 1) : (sreg << 1);

`ifdef SPI_TXC_CRC_EN
    logic        crc_en_q;
    logic [31:0] poly_q;
    logic [31:0] crc;

    always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
        if (!spi_tx_rstn) begin
            crc_en_q <= 1'b0;
            poly_q   <= '0;
        end else if (start) begin
            crc_en_q <= crc_en;
            poly_q   <= crc_poly;
        end
    end

    spi_txc_crc u_crc (
        .clk     (sclk_tx),
        .rst_n   (spi_tx_rstn),
        .clr     (start),
        .en      ((state == ST_DATA) && run),
        .bit_in  (shift_out),
        .df      (df_q),
        .poly    (poly_q),
        .crc     (crc),
        .crc_nxt (crc_nxt)
    );

    assign crc_go       = crc_en_q;
    assign crc_data_out = crc;
`else
    logic unused_crc;

    assign unused_crc   = ^{crc_en, crc_poly};
    assign crc_go       = 1'b0;
    assign crc_nxt      = '0;
    assign crc_data_out = '0;
`endif

    always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
        if (!spi_tx_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        start         = 1'b0;
        shift_out     = 1'b0;
        tx_num_max_en = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt = ST_DATA;
                    start     = 1'b1;
                end
            end
            ST_DATA: begin
                shift_out     = lsbf_q ? sreg[0] : sreg[msb];
                tx_num_max_en = last_frame;
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else if (last_bit && last_frame) begin
                    state_nxt = crc_go ? ST_CRC : ST_IDLE;
                end
            end
            ST_CRC: begin
                shift_out = lsbf_q ? sreg[0] : sreg[msb];
                if (!run || last_bit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Burst configuration is latched at start so mid-burst input changes have no effect.
    always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
        if (!spi_tx_rstn) begin
            df_q      <= DF_8;
            tnum_q    <= '0;
            lsbf_q    <= 1'b0;
            sreg      <= '0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            tx_start  <= 1'b0;
        end else begin
            tx_start <= start;
            if (start) begin
                df_q      <= df;
                tnum_q    <= spi_tnum;
                lsbf_q    <= lsbf;
                sreg      <= spi_tx_data;
                bit_cnt   <= frame_msb(df);
                frame_cnt <= '0;
            end else if (run && (state != ST_IDLE)) begin
                if (!last_bit) begin
                    sreg    <= sreg_shift;
                    bit_cnt <= bit_cnt - 5'd1;
                end else if ((state == ST_DATA) && !last_frame) begin
                    frame_cnt <= frame_cnt + 13'd1;
                    sreg      <= spi_tx_data;
                    bit_cnt   <= msb;
                end else if ((state == ST_DATA) && crc_go) begin
                    sreg    <= crc_nxt;
                    bit_cnt <= msb;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_txc.sv
// tb/tb_spi_txc.sv - self-checking bench for spi_txc against a frame-level reference model
module tb_spi_txc;

`ifdef SPI_TXC_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] spi_tx_data;
    logic [1:0]  df;
    logic [12:0] spi_tnum;
    logic        lsbf, crc_en, txe, rxonly;
    logic [31:0] crc_poly;
    logic [31:0] crc_data_out;
    logic        tx_start, tx_num_max_en, shift_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_txc dut (
        .sclk_tx       (clk),
        .spi_tx_rstn   (rst_n),
        .spi_tx_data   (spi_tx_data),
        .df            (df),
        .spi_tnum      (spi_tnum),
        .lsbf          (lsbf),
        .crc_en        (crc_en),
        .txe           (txe),
        .rxonly        (rxonly),
        .crc_poly      (crc_poly),
        .crc_data_out  (crc_data_out),
        .tx_start      (tx_start),
        .tx_num_max_en (tx_num_max_en),
        .shift_out     (shift_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // CRC as remainder of message(x)*x^W divided by x^W + poly(x), by GF(2) long division.
    function automatic logic [31:0] crc_div(input bit m[$], input int w, input logic [31:0] p);
        bit a[$];
        int n;
        logic [31:0] r;
        n = m.size();
        a = m;
        for (int j = 0; j < w; j++) a.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (a[i])
                for (int j = 1; j <= w; j++) a[i+j] = a[i+j] ^ p[w-j];
        r = '0;
        for (int k = 0; k < w; k++) r[k] = a[n+w-1-k];
        return r;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".shift_out"}, {31'd0, shift_out}, 32'd0);
        check({tag, ".tx_start"}, {31'd0, tx_start}, 32'd0);
        check({tag, ".max_en"}, {31'd0, tx_num_max_en}, 32'd0);
    endtask

    // Caller is at a negedge; burst starts on the next posedge, ends in the idle cycle.
    task automatic run_burst(input logic [1:0] d, input int tn, input bit lf, input bit ce,
                             input logic [31:0] pl, input logic [31:0] dat, input string tag);
        int w;
        bit ebits[$];
        bit emax[$];
        bit msg[$];
        logic [31:0] ecrc;
        w = (d == 2'b01) ? 16 : (d == 2'b10) ? 32 : 8;
        for (int f = 0; f <= tn; f++)
            for (int k = 0; k < w; k++) begin
                ebits.push_back(lf ? dat[k] : dat[w-1-k]);
                msg.push_back(lf ? dat[k] : dat[w-1-k]);
                emax.push_back(f == tn);
            end
        ecrc = CRC_ON ? crc_div(msg, w, pl) : 32'd0;
        if (CRC_ON && ce)
            for (int k = 0; k < w; k++) begin
                ebits.push_back(lf ? ecrc[k] : ecrc[w-1-k]);
                emax.push_back(1'b0);
            end
        df = d; spi_tnum = 13'(tn); lsbf = lf; crc_en = ce; crc_poly = pl;
        spi_tx_data = dat; txe = 1'b1; rxonly = 1'b0;
        for (int i = 0; i < ebits.size(); i++) begin
            @(negedge clk);
            check({tag, ".tx_start"}, {31'd0, tx_start}, {31'd0, i == 0});
            check($sformatf("%s.bit%0d", tag, i), {31'd0, shift_out}, {31'd0, ebits[i]});
            check($sformatf("%s.max%0d", tag, i), {31'd0, tx_num_max_en}, {31'd0, emax[i]});
            if (i == 0) begin
                df = 2'($urandom); spi_tnum = 13'($urandom); lsbf = 1'($urandom);
                crc_en = 1'($urandom); crc_poly = $urandom;
            end
        end
        @(negedge clk);
        check_idle({tag, ".end"});
        check({tag, ".crc"}, crc_data_out, ecrc);
        txe = 1'b0;
    endtask

    task automatic abort_test(input bit use_rx, input string tag);
        df = 2'b10; spi_tnum = 13'd0; lsbf = 1'b0; crc_en = 1'b1; crc_poly = 32'h04C11DB7;
        spi_tx_data = 32'hFFFF_FFFF; txe = 1'b1; rxonly = 1'b0;
        @(negedge clk);
        check({tag, ".start"}, {31'd0, tx_start}, 32'd1);
        check({tag, ".bit0"}, {31'd0, shift_out}, 32'd1);
        check({tag, ".max"}, {31'd0, tx_num_max_en}, 32'd1);
        @(negedge clk);
        if (use_rx) rxonly = 1'b1;
        else txe = 1'b0;
        @(negedge clk);
        check_idle({tag, ".aborted"});
        @(negedge clk);
        check_idle({tag, ".stays"});
        txe = 1'b0; rxonly = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; spi_tx_data = '0; df = '0; spi_tnum = '0; lsbf = 1'b0;
        crc_en = 1'b0; txe = 1'b0; rxonly = 1'b0; crc_poly = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset.crc", crc_data_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        run_burst(2'b00, 4, 1'b0, 1'b0, 32'h0, 32'h1234_5678, "spec8");
        run_burst(2'b01, 2, 1'b1, 1'b0, 32'h0, 32'hAABB_CCDD, "spec16");
        run_burst(2'b00, 0, 1'b0, 1'b1, 32'h07, 32'h0000_0001, "crc8");
        run_burst(2'b10, 1, 1'b0, 1'b1, 32'h04C1_1DB7, 32'h8765_4321, "crc32");
        run_burst(2'b11, 1, 1'b1, 1'b1, 32'h1D, 32'h0000_00A5, "rsvd_df");
        @(negedge clk);
        check_idle("gap");

        spi_tx_data = 32'hFFFF_FFFF; df = 2'b10; rxonly = 1'b1; txe = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("rxonly.shift_out", {31'd0, shift_out}, 32'd0);
            check("rxonly.tx_start", {31'd0, tx_start}, 32'd0);
        end
        rxonly = 1'b0; txe = 1'b0;
        @(negedge clk);

        abort_test(1'b0, "abort_txe");
        abort_test(1'b1, "abort_rx");

        df = 2'b10; spi_tnum = 13'd0; lsbf = 1'b1; crc_en = 1'b1; crc_poly = 32'hF0F0_1234;
        spi_tx_data = 32'hFFFF_FFFF; txe = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle("midreset");
        check("midreset.crc", crc_data_out, 32'd0);
        txe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_burst(2'b01, 1, 1'b0, 1'b1, 32'h8005, 32'h0000_1357, "after_reset");

        for (int r = 0; r < 14; r++)
            run_burst(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
                      1'($urandom), $urandom, $urandom, $sformatf("rnd%0d", r));
        @(negedge clk);
        check_idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
